// File: rtl/data_sram_if.sv
// data_sram_if: request/response bus between a data-SRAM master and the responder.
interface data_sram_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: fixed-latency data SRAM responder with bounded outstanding requests and in-order replies.
module data_sram_resp #(
   parameter int MEM_AW      = 10,
   parameter int LATENCY     = 2,
   parameter int OUTSTANDING = 2
) (
   input logic        clk,
   input logic        reset,
   input logic        stall,
   data_sram_if.slave bus
);
   localparam logic [1:0] LAST = 2'(OUTSTANDING - 1);
   localparam logic [1:0] LD   = 2'(LATENCY - 1);
   logic [31:0]       mem [2**MEM_AW];
   logic [31:0]       e_data [4];
   logic [1:0]        e_cnt [4];
   logic [3:0]        e_vld;
   logic [1:0]        wr_ptr, rd_ptr;
   logic [2:0]        count;
   logic              accept, misaligned, pop, unused_hi;
   logic [MEM_AW-1:0] idx;
   function automatic logic [1:0] nxt(input logic [1:0] p);
      return p == LAST ? 2'd0 : p + 2'd1;
   endfunction
   assign idx        = bus.data_sram_addr[MEM_AW+1:2];
   assign unused_hi  = ^bus.data_sram_addr[31:MEM_AW+2];
   assign misaligned = (bus.data_sram_size == 2'd1 & bus.data_sram_addr[0]) |
                       (bus.data_sram_size[1] & |bus.data_sram_addr[1:0]);
   assign bus.data_sram_addr_ok = bus.data_sram_req & ~stall & ~reset &
                                  (count < 3'(OUTSTANDING) | bus.data_sram_data_ok);
   assign accept = bus.data_sram_req & bus.data_sram_addr_ok;
   assign pop    = e_vld[rd_ptr] & e_cnt[rd_ptr] == 2'd0;
   always_ff @(posedge clk) begin
      if (accept & bus.data_sram_wr & ~misaligned)
         for (int i = 0; i < 4; i++)
            if (bus.data_sram_wstrb[i]) mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
   end
   // The head entry retires the edge its counter has reached zero, which
   // places data_ok exactly LATENCY edges after the accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         count                 <= 3'd0;
         e_vld                 <= 4'd0;
         wr_ptr                <= 2'd0;
         rd_ptr                <= 2'd0;
         bus.data_sram_data_ok <= 1'b0;
         bus.data_sram_rdata   <= 32'h0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (e_vld[i] & e_cnt[i] != 2'd0) e_cnt[i] <= e_cnt[i] - 2'd1;
         if (pop) begin
            e_vld[rd_ptr]       <= 1'b0;
            rd_ptr              <= nxt(rd_ptr);
            bus.data_sram_rdata <= e_data[rd_ptr];
         end
         bus.data_sram_data_ok <= pop;
         if (accept) begin
            e_vld[wr_ptr]  <= 1'b1;
            e_cnt[wr_ptr]  <= LD;
            e_data[wr_ptr] <= (bus.data_sram_wr | misaligned) ? 32'h0 : mem[idx];
            wr_ptr         <= nxt(wr_ptr);
         end
         count <= count + 3'(accept) - 3'(bus.data_sram_data_ok);
      end
   end
endmodule
